// File: rtl/sevseg_capture.sv
// Readback monitor for a multiplexed active-low seven-segment bus: filters each
// digit's pattern for stability, inverse-decodes it and keeps per-digit results.
module sevseg_capture #(
   parameter int DIGITS = 4,
   parameter int STABLE = 3
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [6:0]          seg_n,
   input  logic [DIGITS-1:0]   an_n,
   input  logic                clr_err,
   output logic [4*DIGITS-1:0] value,
   output logic [DIGITS-1:0]   digit_valid,
   output logic                upd,
   output logic                err,
   output logic                frame_done
);

   localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_DWELL,
      S_HELD
   } state_t;

   state_t            state_q, state_d;
   logic [6:0]        seg_q, seg_prev_q;
   logic [DIGITS-1:0] an_q, an_prev_q;
   logic [3:0]        run_q, run_d;
   logic [3:0]        val_q [DIGITS];
   logic [DIGITS-1:0] valid_q;
   logic [DIGITS-1:0] seen_q, seen_d;
   logic              upd_q, err_q, frame_q, frame_d;

   logic              active, changed, commit, legal;
   logic [3:0]        nib;
   logic [3:0]        act_cnt;
   logic [IW-1:0]     act_idx;

   // Inverse of the nibble-to-segment encoder; anything else is illegal.
   always_comb begin
      legal = 1'b1;
      nib   = 4'h0;
      case (seg_q)
         7'b0000001: nib = 4'h0;
         7'b1001111: nib = 4'h1;
         7'b0010010: nib = 4'h2;
         7'b0000110: nib = 4'h3;
         7'b1001100: nib = 4'h4;
         7'b0100100: nib = 4'h5;
         7'b0100000: nib = 4'h6;
         7'b0001111: nib = 4'h7;
         7'b0000000: nib = 4'h8;
         7'b0001100: nib = 4'h9;
         7'b0001000: nib = 4'hA;
         7'b1100000: nib = 4'hB;
         7'b0110001: nib = 4'hC;
         7'b1000010: nib = 4'hD;
         7'b0110000: nib = 4'hE;
         7'b0111000: nib = 4'hF;
         default:    legal = 1'b0;
      endcase
   end

   always_comb begin
      act_cnt = 4'd0;
      act_idx = '0;
      for (int k = 0; k < DIGITS; k++) begin
         if (!an_q[k]) begin
            act_cnt = act_cnt + 4'd1;
            act_idx = IW'(k);
         end
      end
      active  = (act_cnt == 4'd1);
      // Leaving IDLE always starts a fresh dwell, even right after reset.
      changed = (seg_q != seg_prev_q) || (an_q != an_prev_q) || (state_q == S_IDLE);

      if (!active)                   run_d = 4'd0;
      else if (changed)              run_d = 4'd1;
      else if (run_q < 4'(STABLE))   run_d = run_q + 4'd1;
      else                           run_d = run_q;

      commit = active && (state_q != S_HELD) && (run_d == 4'(STABLE));

      if (!active)      state_d = S_IDLE;
      else if (commit)  state_d = S_HELD;
      else if (changed) state_d = S_DWELL;
      else              state_d = state_q;

      seen_d = seen_q;
      if (commit) seen_d[act_idx] = 1'b1;
      frame_d = &seen_d;
      if (frame_d) seen_d = '0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         seg_q      <= '1;
         seg_prev_q <= '1;
         an_q       <= '1;
         an_prev_q  <= '1;
         run_q      <= 4'd0;
         state_q    <= S_IDLE;
         for (int k = 0; k < DIGITS; k++) val_q[k] <= 4'h0;
         valid_q    <= '0;
         seen_q     <= '0;
         upd_q      <= 1'b0;
         err_q      <= 1'b0;
         frame_q    <= 1'b0;
      end else begin
         seg_q      <= seg_n;
         seg_prev_q <= seg_q;
         an_q       <= an_n;
         an_prev_q  <= an_q;
         run_q      <= run_d;
         state_q    <= state_d;
         seen_q     <= seen_d;
         frame_q    <= frame_d;
         upd_q      <= 1'b0;
         if (commit) begin
            if (legal) begin
               val_q[act_idx]   <= nib;
               valid_q[act_idx] <= 1'b1;
               upd_q            <= !valid_q[act_idx] || (val_q[act_idx] != nib);
            end else begin
               valid_q[act_idx] <= 1'b0;
            end
         end
         // An illegal commit outranks a simultaneous clear.
         if (commit && !legal) err_q <= 1'b1;
         else if (clr_err)     err_q <= 1'b0;
      end
   end

   for (genvar g = 0; g < DIGITS; g++) begin : g_value
      assign value[4*g +: 4] = val_q[g];
   end

   assign digit_valid = valid_q;
   assign upd         = upd_q;
   assign err         = err_q;
   assign frame_done  = frame_q;

endmodule
